// File: rtl/slot_alloc_pkg.sv
// Shared definitions for the slot allocator: default pool geometry and the
// ceil(log2) helper used to size slot indices.
package slot_alloc_pkg;

    // Smallest r with 2**r >= n; returns at least 1 so a 2-slot pool still gets a 1-bit index.
    function automatic int clog2_f(input int n);
        int r;
        r = 1;
        while ((1 << r) < n) r++;
        return r;
    endfunction

    localparam int NSLOT_DEF = 48;
    localparam int IDWID_DEF = clog2_f(NSLOT_DEF);

endpackage

// File: rtl/slot_alloc_decodex.sv
// Index to one-hot decoder with enable. Indices at or above N decode to all-zero,
// which the allocator relies on to reject out-of-range releases.
module decodex
    import slot_alloc_pkg::*;
#(
    parameter int N = NSLOT_DEF,
    parameter int W = IDWID_DEF
) (
    input  logic [W-1:0] idx,
    input  logic         en,
    output logic [N-1:0] onehot
);

    // One-hot decode; bit i set only when enabled and idx equals i.
    always_comb begin
        for (int i = 0; i < N; i++) begin
            onehot[i] = en && (idx == W'(i));
        end
    end

endmodule

// File: rtl/slot_alloc_rr_ffs.sv
// Rotating find-first-set: returns the lowest set bit at or above ptr, wrapping
// to the lowest set bit overall when nothing is set at or above ptr.
// Built as two parallel priority encoders plus a final select, so the critical
// path is one compare-and-mask followed by one encoder rather than a rotator.
module rr_ffs
    import slot_alloc_pkg::*;
#(
    parameter int N = NSLOT_DEF,
    parameter int W = IDWID_DEF
) (
    input  logic [N-1:0] vec,
    input  logic [W-1:0] ptr,
    output logic         found,
    output logic [W-1:0] idx
);

    logic [N-1:0] hi_vec;
    logic         hi_found;
    logic [W-1:0] hi_idx;
    logic         lo_found;
    logic [W-1:0] lo_idx;

    // Keep only candidates at or above the search start.
    always_comb begin
        for (int i = 0; i < N; i++) begin
            hi_vec[i] = vec[i] && (W'(i) >= ptr);
        end
    end

    // Lowest set bit of the masked vector (the non-wrapping search).
    always_comb begin
        // NOTE: every combinational output gets a default first, so no path can leave it unassigned and infer a latch.
        hi_found = 1'b0;
        hi_idx   = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (hi_vec[i]) begin
                hi_found = 1'b1;
                hi_idx   = W'(i);
            end
        end
    end

    // Lowest set bit of the full vector (the wrapped search).
    always_comb begin
        lo_found = 1'b0;
        lo_idx   = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (vec[i]) begin
                lo_found = 1'b1;
                lo_idx   = W'(i);
            end
        end
    end

    // Prefer the non-wrapping hit; fall back to the wrapped one.
    always_comb begin
        found = hi_found || lo_found;
        idx   = hi_found ? hi_idx : lo_idx;
    end

endmodule

// File: rtl/slot_alloc.sv
// Free-slot allocator: free bitmap, rotating search pointer and occupancy counter.
// Grants are answered one cycle after the request; releases take effect at the
// same edge, and flush returns the whole pool.
module slot_alloc
    import slot_alloc_pkg::*;
#(
    parameter int NSLOT = NSLOT_DEF,
    parameter int IDWID = IDWID_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             alloc_req,
    output logic             alloc_ack,
    output logic             alloc_ok,
    output logic [IDWID-1:0] alloc_id,
    output logic [NSLOT-1:0] alloc_map,
    input  logic             rel_vld,
    input  logic [IDWID-1:0] rel_id,
    output logic             rel_err,
    input  logic             flush,
    output logic [IDWID:0]   used_cnt,
    output logic             full,
    output logic             empty
);

    localparam logic [IDWID:0]   CNT_FULL = (IDWID + 1)'(NSLOT);
    localparam logic [IDWID-1:0] LAST_ID  = IDWID'(NSLOT - 1);

    logic [NSLOT-1:0] free;
    logic [IDWID-1:0] ptr;

    logic             found;
    logic [IDWID-1:0] ffs_idx;
    logic             grant;
    logic [NSLOT-1:0] grant_mask;
    logic [NSLOT-1:0] rel_mask;
    logic             rel_hit;
    logic             rel_ok;
    logic             rel_bad;
    logic [NSLOT-1:0] free_next;
    logic [IDWID:0]   cnt_next;
    logic [IDWID-1:0] ptr_next;

    // Search the pre-release bitmap so a slot being released cannot be regranted this cycle.
    rr_ffs #(.N(NSLOT), .W(IDWID)) u_ffs (
        .vec   (free),
        .ptr   (ptr),
        .found (found),
        .idx   (ffs_idx)
    );

    decodex #(.N(NSLOT), .W(IDWID)) u_grant_dec (
        .idx    (ffs_idx),
        .en     (grant),
        .onehot (grant_mask)
    );

    // Out-of-range rel_id decodes to zero, so it can never hit an allocated slot.
    decodex #(.N(NSLOT), .W(IDWID)) u_rel_dec (
        .idx    (rel_id),
        .en     (rel_vld),
        .onehot (rel_mask)
    );

    // Next-state for bitmap, pointer and counter; flush overrides alloc and release.
    always_comb begin
        grant    = alloc_req && found && !flush;
        rel_hit  = |(rel_mask & ~free);
        rel_ok   = rel_vld && rel_hit && !flush;
        rel_bad  = rel_vld && !rel_hit && !flush;
        free_next = (free & ~grant_mask) | (rel_ok ? rel_mask : '0);
        cnt_next  = used_cnt;
        ptr_next  = ptr;
        if (grant) begin
            ptr_next = (ffs_idx == LAST_ID) ? '0 : ffs_idx + IDWID'(1);
        end
        case ({grant, rel_ok})
            2'b10:   cnt_next = used_cnt + (IDWID + 1)'(1);
            2'b01:   cnt_next = used_cnt - (IDWID + 1)'(1);
            default: cnt_next = used_cnt;
        endcase
        if (flush) begin
            free_next = '1;
            cnt_next  = '0;
            ptr_next  = '0;
        end
    end

    // State and registered outputs; full/empty derive from the next count so they track used_cnt.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            free      <= '1;
            ptr       <= '0;
            used_cnt  <= '0;
            full      <= 1'b0;
            empty     <= 1'b1;
            alloc_ack <= 1'b0;
            alloc_ok  <= 1'b0;
            alloc_id  <= '0;
            alloc_map <= '0;
            rel_err   <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
            free      <= free_next;
            ptr       <= ptr_next;
            used_cnt  <= cnt_next;
            full      <= (cnt_next == CNT_FULL);
            empty     <= (cnt_next == '0);
            alloc_ack <= alloc_req;
            alloc_ok  <= grant;
            alloc_id  <= grant ? ffs_idx : '0;
            alloc_map <= grant_mask;
            rel_err   <= rel_bad;
        end
    end

endmodule

// File: tb/tb_slot_alloc.sv
// Directed bench for slot_alloc: table-driven vectors for release/flush/concurrency
// cases plus hand sequences for bursts, rotation wrap and asynchronous reset.
module tb_slot_alloc;

    localparam int NSLOT = 48;
    localparam int IDWID = 6;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             alloc_req;
    logic             alloc_ack;
    logic             alloc_ok;
    logic [IDWID-1:0] alloc_id;
    logic [NSLOT-1:0] alloc_map;
    logic             rel_vld;
    logic [IDWID-1:0] rel_id;
    logic             rel_err;
    logic             flush;
    logic [IDWID:0]   used_cnt;
    logic             full;
    logic             empty;

    int total = 0;
    int bad   = 0;

    typedef struct {
        bit req;
        bit rv;
        int rid;
        bit fl;
        bit e_ack;
        bit e_ok;
        int e_id;
        int e_used;
        bit e_err;
    } vec_t;

    vec_t tab_a [7];
    vec_t tab_b [7];

    slot_alloc #(.NSLOT(NSLOT), .IDWID(IDWID)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .alloc_req (alloc_req),
        .alloc_ack (alloc_ack),
        .alloc_ok  (alloc_ok),
        .alloc_id  (alloc_id),
        .alloc_map (alloc_map),
        .rel_vld   (rel_vld),
        .rel_id    (rel_id),
        .rel_err   (rel_err),
        .flush     (flush),
        .used_cnt  (used_cnt),
        .full      (full),
        .empty     (empty)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_out(input string tag, input bit e_ack, input bit e_ok,
                             input int e_id, input int e_used, input bit e_err);
        logic [NSLOT-1:0] e_map;
        e_map = '0;
        if (e_ok) e_map[e_id] = 1'b1;
        check({tag, ".ack"},   64'(alloc_ack), 64'(e_ack));
        check({tag, ".ok"},    64'(alloc_ok),  64'(e_ok));
        check({tag, ".id"},    64'(alloc_id),  64'(e_id));
        check({tag, ".map"},   64'(alloc_map), 64'(e_map));
        check({tag, ".used"},  64'(used_cnt),  64'(e_used));
        check({tag, ".full"},  64'(full),      64'(e_used == NSLOT));
        check({tag, ".empty"}, 64'(empty),     64'(e_used == 0));
        check({tag, ".err"},   64'(rel_err),   64'(e_err));
    endtask

    // Advance one clock and settle just after the rising edge.
    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic do_alloc(input int e_id, input int e_used, input string tag);
        alloc_req = 1'b1;
        cycle();
        check_out(tag, 1'b1, 1'b1, e_id, e_used, 1'b0);
        alloc_req = 1'b0;
    endtask

    task automatic run_vec(input vec_t v, input string tag);
        alloc_req = v.req;
        rel_vld   = v.rv;
        rel_id    = IDWID'(v.rid);
        flush     = v.fl;
        cycle();
        check_out(tag, v.e_ack, v.e_ok, v.e_id, v.e_used, v.e_err);
        alloc_req = 1'b0;
        rel_vld   = 1'b0;
        rel_id    = '0;
        flush     = 1'b0;
    endtask

    initial begin
        //             req rv rid fl  ack ok id used err
        // Starts full with ptr=0 after the 48-slot burst.
        tab_a[0] = '{1'b1, 1'b1,  5, 1'b0, 1'b1, 1'b0,  0, 47, 1'b0};
        tab_a[1] = '{1'b1, 1'b0,  0, 1'b0, 1'b1, 1'b1,  5, 48, 1'b0};
        tab_a[2] = '{1'b0, 1'b1,  7, 1'b0, 1'b0, 1'b0,  0, 47, 1'b0};
        tab_a[3] = '{1'b0, 1'b1,  2, 1'b0, 1'b0, 1'b0,  0, 46, 1'b0};
        tab_a[4] = '{1'b1, 1'b0,  0, 1'b0, 1'b1, 1'b1,  7, 47, 1'b0};
        tab_a[5] = '{1'b1, 1'b1,  9, 1'b1, 1'b1, 1'b0,  0,  0, 1'b0};
        tab_a[6] = '{1'b1, 1'b0,  0, 1'b0, 1'b1, 1'b1,  0,  1, 1'b0};
        // Starts full with ptr=4 after the wrap to id 3.
        tab_b[0] = '{1'b0, 1'b1, 20, 1'b0, 1'b0, 1'b0,  0, 47, 1'b0};
        tab_b[1] = '{1'b0, 1'b1, 20, 1'b0, 1'b0, 1'b0,  0, 47, 1'b1};
        tab_b[2] = '{1'b0, 1'b0,  0, 1'b0, 1'b0, 1'b0,  0, 47, 1'b0};
        tab_b[3] = '{1'b0, 1'b1, 50, 1'b0, 1'b0, 1'b0,  0, 47, 1'b1};
        tab_b[4] = '{1'b0, 1'b0,  0, 1'b0, 1'b0, 1'b0,  0, 47, 1'b0};
        tab_b[5] = '{1'b1, 1'b1, 21, 1'b0, 1'b1, 1'b1, 20, 47, 1'b0};
        tab_b[6] = '{1'b1, 1'b0,  0, 1'b0, 1'b1, 1'b1, 21, 48, 1'b0};

        rst_n     = 1'b0;
        alloc_req = 1'b0;
        rel_vld   = 1'b0;
        rel_id    = '0;
        flush     = 1'b0;
        repeat (2) cycle();
        check_out("reset", 1'b0, 1'b0, 0, 0, 1'b0);
        rst_n = 1'b1;

        // Burst: ids 0..47 in order, then the pool is full.
        for (int i = 0; i < NSLOT; i++) do_alloc(i, i + 1, "burst");
        alloc_req = 1'b1;
        cycle();
        check_out("alloc_when_full", 1'b1, 1'b0, 0, 48, 1'b0);
        alloc_req = 1'b0;

        // Release-while-full, pointer position, flush with concurrent traffic.
        for (int i = 0; i < 7; i++) run_vec(tab_a[i], $sformatf("tab_a%0d", i));

        // Rotation: 0..9 held, free 3, next grant continues at 10 and wraps to 3.
        for (int i = 1; i < 10; i++) do_alloc(i, i + 1, "rot_fill");
        rel_vld = 1'b1;
        rel_id  = 6'd3;
        cycle();
        check_out("rel3", 1'b0, 1'b0, 0, 9, 1'b0);
        rel_vld = 1'b0;
        do_alloc(10, 10, "rot_skip3");
        for (int i = 11; i < NSLOT; i++) do_alloc(i, i, "rot_rest");
        do_alloc(3, 48, "rot_wrap");

        // Invalid releases and concurrent alloc+release with free slots.
        for (int i = 0; i < 7; i++) run_vec(tab_b[i], $sformatf("tab_b%0d", i));

        // Async reset in the middle of a burst.
        flush = 1'b1;
        cycle();
        check_out("flush2", 1'b0, 1'b0, 0, 0, 1'b0);
        flush = 1'b0;
        for (int i = 0; i < 17; i++) do_alloc(i, i + 1, "pre_reset");
        alloc_req = 1'b1;
        #2;
        rst_n = 1'b0;
        #1;
        check_out("async_reset", 1'b0, 1'b0, 0, 0, 1'b0);
        cycle();
        check_out("held_reset", 1'b0, 1'b0, 0, 0, 1'b0);
        alloc_req = 1'b0;
        rst_n = 1'b1;
        do_alloc(0, 1, "post_reset");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
